// File: rtl/conv_layer_input_ctrl.sv
// conv_layer_input_ctrl
// Sequencer for the conv-layer input interface. It walks one IMAGE_SIZE x IMAGE_SIZE
// frame through a PRELOAD command, then alternating SHIFT / LOAD commands (one SHIFT
// per output row). Each command is a one-cycle pulse on cmd, followed by a wait for the
// matching ack code. Every wait is guarded by a watchdog that parks the sequencer in an
// error state. All outputs are registered: the next-cycle values are decoded from the
// next state and captured together with the state register.
module conv_layer_input_ctrl #(
    parameter int IMAGE_SIZE  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_WIDTH   = 3,
    parameter int TMO_WIDTH   = 8,
    parameter int TIMEOUT     = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           ack,
    output logic [1:0]           cmd,
    output logic                 iface_en,
    output logic [ROW_WIDTH-1:0] row_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int OUT_ROWS = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(OUT_ROWS - 1);
    // The last tolerated wait cycle carries count TIMEOUT-1; no ack there means
    // TIMEOUT cycles have been spent waiting.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT - 1);

    localparam logic [1:0] CMD_IDLE    = 2'd0;
    localparam logic [1:0] CMD_PRELOAD = 2'd1;
    localparam logic [1:0] CMD_SHIFT   = 2'd2;
    localparam logic [1:0] CMD_LOAD    = 2'd3;

    localparam logic [1:0] ACK_PRELOAD = 2'd1;
    localparam logic [1:0] ACK_SHIFT   = 2'd2;
    localparam logic [1:0] ACK_LOAD    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_ISS,
        S_PRE_WAIT,
        S_SH_ISS,
        S_SH_WAIT,
        S_LD_ISS,
        S_LD_WAIT,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [TMO_WIDTH-1:0]   wdog_q, wdog_d;
    logic [ROW_WIDTH-1:0]   row_d;
    logic [1:0]             cmd_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   error_d;

    // Next-state, watchdog, row counter and next-cycle output decode.
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        row_d   = row_idx;
        done_d  = 1'b0;
        error_d = error;

        if (abort && (state_q != S_IDLE)) begin
            // Abort wins over any ack arriving in the same cycle; error stays sticky.
            state_d = S_IDLE;
            row_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_PRE_ISS;
                        row_d   = '0;
                        error_d = 1'b0;
                    end
                end
                S_PRE_ISS: begin
                    state_d = S_PRE_WAIT;
                    wdog_d  = '0;
                end
                S_PRE_WAIT: begin
                    if (ack == ACK_PRELOAD) begin
                        state_d = S_SH_ISS;
                    end else if (wdog_q == TMO_LAST) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + TMO_WIDTH'(1);
                    end
                end
                S_SH_ISS: begin
                    state_d = S_SH_WAIT;
                    wdog_d  = '0;
                end
                S_SH_WAIT: begin
                    if (ack == ACK_SHIFT) begin
                        if (row_idx == ROW_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_LD_ISS;
                        end
                    end else if (wdog_q == TMO_LAST) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + TMO_WIDTH'(1);
                    end
                end
                S_LD_ISS: begin
                    state_d = S_LD_WAIT;
                    wdog_d  = '0;
                end
                S_LD_WAIT: begin
                    if (ack == ACK_LOAD) begin
                        state_d = S_SH_ISS;
                        row_d   = row_idx + ROW_WIDTH'(1);
                    end else if (wdog_q == TMO_LAST) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + TMO_WIDTH'(1);
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs for the next cycle follow directly from the next state.
        case (state_d)
            S_PRE_ISS: cmd_d = CMD_PRELOAD;
            S_SH_ISS:  cmd_d = CMD_SHIFT;
            S_LD_ISS:  cmd_d = CMD_LOAD;
            default:   cmd_d = CMD_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_ERR);
    end

    // State, counters and all registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wdog_q   <= '0;
            row_idx  <= '0;
            cmd      <= CMD_IDLE;
            iface_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            row_idx  <= row_d;
            cmd      <= cmd_d;
            iface_en <= busy_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
        end
    end

endmodule
